// File: rtl/ch_est_interp.sv
// Expands four pilot channel estimates (subcarriers 0/3/6/9) into a 12-subcarrier
// stream using linear interpolation, with extrapolation for subcarriers 10 and 11.
module ch_est_interp #(
    parameter int WIDTH_EST = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH_EST-1:0] h0,
    input  logic [WIDTH_EST-1:0] h3,
    input  logic [WIDTH_EST-1:0] h6,
    input  logic [WIDTH_EST-1:0] h9,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [WIDTH_EST-1:0] out_data,
    output logic [3:0]           out_idx,
    output logic                 busy,
    output logic                 done
);
    localparam int W = WIDTH_EST;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    localparam logic [16:0]          COEF_1_3 = 17'd21845;
    localparam logic [16:0]          COEF_2_3 = 17'd43691;
    localparam logic signed [W+17:0] ROUND    = (W+18)'(32768);
    localparam logic [W-1:0]         SAT_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]         SAT_MIN  = {1'b1, {(W-1){1'b0}}};

    logic [0:0]   state;
    logic [W-1:0] s0, s3, s6, s9;

    logic [3:0]              next_idx;
    logic [W-1:0]            base;
    logic [W-1:0]            hi;
    logic [W-1:0]            lo;
    logic                    pilot;
    logic                    two_thirds;
    logic [W:0]              d;
    logic signed [W+17:0]    d_x;
    logic signed [W+17:0]    c_x;
    logic signed [W+17:0]    prod;
    logic signed [W+1:0]     offset;
    logic [W+1:0]            sum;
    logic [W-1:0]            next_val;

    assign next_idx = out_idx + 4'd1;

    always_comb begin
        base       = s0;
        hi         = s3;
        lo         = s0;
        pilot      = 1'b0;
        two_thirds = 1'b0;
        case (next_idx)
            4'd0:  begin base = s0; pilot = 1'b1; end
            4'd1:  begin base = s0; hi = s3; lo = s0; end
            4'd2:  begin base = s0; hi = s3; lo = s0; two_thirds = 1'b1; end
            4'd3:  begin base = s3; pilot = 1'b1; end
            4'd4:  begin base = s3; hi = s6; lo = s3; end
            4'd5:  begin base = s3; hi = s6; lo = s3; two_thirds = 1'b1; end
            4'd6:  begin base = s6; pilot = 1'b1; end
            4'd7:  begin base = s6; hi = s9; lo = s6; end
            4'd8:  begin base = s6; hi = s9; lo = s6; two_thirds = 1'b1; end
            4'd9:  begin base = s9; pilot = 1'b1; end
            4'd10: begin base = s9; hi = s9; lo = s6; end
            4'd11: begin base = s9; hi = s9; lo = s6; two_thirds = 1'b1; end
            default: begin base = s0; pilot = 1'b1; end
        endcase
    end

    // Pilots take a zero slope so they share the rounding/saturation path.
    always_comb begin
        d        = pilot ? '0 : ({hi[W-1], hi} - {lo[W-1], lo});
        d_x      = {{17{d[W]}}, d};
        c_x      = {{(W+1){1'b0}}, (two_thirds ? COEF_2_3 : COEF_1_3)};
        prod     = d_x * c_x;
        offset   = (W+2)'((prod + ROUND) >>> 16);
        sum      = {{2{base[W-1]}}, base} + offset;
        next_val = sum[W-1:0];
        if (!((sum[W+1:W-1] == 3'b000) || (sum[W+1:W-1] == 3'b111)))
            next_val = sum[W+1] ? SAT_MIN : SAT_MAX;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            s0        <= '0;
            s3        <= '0;
            s6        <= '0;
            s9        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        s0        <= h0;
                        s3        <= h3;
                        s6        <= h6;
                        s9        <= h9;
                        out_idx   <= '0;
                        out_data  <= h0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= STREAM;
                    end
                end
                default: begin
                    if (out_valid && out_ready) begin
                        if (out_idx == 4'd11) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            out_idx  <= next_idx;
                            out_data <= next_val;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ch_est_interp.sv
// Directed bench for ch_est_interp: interpolation, backpressure, saturation,
// snapshot behaviour, mid-burst reset and back-to-back bursts.
module tb_ch_est_interp;
    localparam int W = 17;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] h0, h3, h6, h9;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [3:0]   out_idx;
    logic         busy;
    logic         done;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;

    int exp_basic[12]  = '{100, 200, 300, 400, 300, 200, 100, 0, -100, -200, -300, -400};
    int exp_satp[12]   = '{0, 0, 0, 0, 0, 0, 0, 20000, 40000, 60000, 65535, 65535};
    int exp_satn[12]   = '{0, 0, 0, 0, 0, 0, 0, -20000, -40000, -60000, -65536, -65536};
    int exp_second[12] = '{0, 1, 2, 3, 1, -1, -3, 0, 3, 6, 9, 12};

    ch_est_interp #(.WIDTH_EST(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .h0(h0), .h3(h3), .h6(h6), .h9(h9),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_idx(out_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;
    always @(posedge clk) if (out_valid === 1'b1 && out_ready === 1'b1) xfer_cnt++;

    task automatic set_h(input int a, input int b, input int c, input int e);
        h0 = W'(a); h3 = W'(b); h6 = W'(c); h9 = W'(e);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; out_ready = 1'b1; set_h(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, out_data, out_idx, busy, done} !== '0)
            $display("FAIL reset_state: valid=%b data=%0d idx=%0d busy=%b done=%b, required all 0",
                     out_valid, out_data, out_idx, busy, done);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [W-1:0] e;
        set_h(100, 400, 100, -200); out_ready = 1'b1; done_cnt = 0;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            e = W'(exp_basic[i]);
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_idx !== 4'(i) || out_data !== e)
                $display("FAIL basic_idx%0d: valid=%b busy=%b idx=%0d data=%0d, required 1 1 %0d %0d",
                         i, out_valid, busy, out_idx, $signed(out_data), i, exp_basic[i]);
            else passed++;
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL basic_done: done=%b busy=%b valid=%b, required 1 0 0", done, busy, out_valid);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0 || done_cnt !== 1)
            $display("FAIL basic_done_once: done=%b count=%0d, required 0 and 1", done, done_cnt);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e;
        set_h(100, 400, 100, -200); out_ready = 1'b1; xfer_cnt = 0;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            e = W'(exp_basic[i]);
            total++;
            if (out_valid !== 1'b1 || out_idx !== 4'(i) || out_data !== e)
                $display("FAIL bp_idx%0d: valid=%b idx=%0d data=%0d, required 1 %0d %0d",
                         i, out_valid, out_idx, $signed(out_data), i, exp_basic[i]);
            else passed++;
            if (i == 4) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    total++;
                    if (out_valid !== 1'b1 || out_idx !== 4'd4 || out_data !== W'(300))
                        $display("FAIL bp_hold: valid=%b idx=%0d data=%0d, required 1 4 300",
                                 out_valid, out_idx, $signed(out_data));
                    else passed++;
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        @(negedge clk);
        total++;
        if (xfer_cnt !== 12)
            $display("FAIL bp_transfers: got %0d, required 12", xfer_cnt);
        else passed++;
    endtask

    task automatic test_saturation(input logic neg);
        logic [W-1:0] e;
        set_h(0, 0, 0, neg ? -60000 : 60000); out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            e = neg ? W'(exp_satn[i]) : W'(exp_satp[i]);
            if (i >= 7) begin
                total++;
                if (out_idx !== 4'(i) || out_data !== e)
                    $display("FAIL sat%s_idx%0d: idx=%0d data=%0d, required %0d %0d", neg ? "neg" : "pos",
                             i, out_idx, $signed(out_data), i, $signed(e));
                else passed++;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_snapshot();
        logic [W-1:0] e;
        set_h(100, 400, 100, -200); out_ready = 1'b1; done_cnt = 0;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            if (i == 3) begin set_h(-5000, 7000, 123, 9999); start = 1'b1; end
            if (i == 5) start = 1'b0;
            e = W'(exp_basic[i]);
            total++;
            if (out_idx !== 4'(i) || out_data !== e)
                $display("FAIL snap_idx%0d: idx=%0d data=%0d, required %0d %0d",
                         i, out_idx, $signed(out_data), i, exp_basic[i]);
            else passed++;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        total++;
        if (done_cnt !== 1 || busy !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL snap_single_done: count=%0d busy=%b valid=%b, required 1 0 0",
                     done_cnt, busy, out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] e;
        set_h(100, 400, 100, -200); out_ready = 1'b1;
        pulse_start();
        repeat (5) @(negedge clk);
        total++;
        if (out_idx !== 4'd5)
            $display("FAIL rstmid_reach: idx=%0d, required 5", out_idx);
        else passed++;
        done_cnt = 0;
        rst = 1'b0;
        #1;
        total++;
        if ({out_valid, out_data, out_idx, busy, done} !== '0)
            $display("FAIL rstmid_clear: valid=%b data=%0d idx=%0d busy=%b done=%b, required all 0",
                     out_valid, out_data, out_idx, busy, done);
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt !== 0 || out_valid !== 1'b0)
            $display("FAIL rstmid_no_done: count=%0d valid=%b, required 0 0", done_cnt, out_valid);
        else passed++;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            e = W'(exp_basic[i]);
            total++;
            if (out_valid !== 1'b1 || out_idx !== 4'(i) || out_data !== e)
                $display("FAIL rstmid_idx%0d: valid=%b idx=%0d data=%0d, required 1 %0d %0d",
                         i, out_valid, out_idx, $signed(out_data), i, exp_basic[i]);
            else passed++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        set_h(100, 400, 100, -200); out_ready = 1'b1;
        pulse_start();
        repeat (12) @(negedge clk);
        total++;
        if (done !== 1'b1)
            $display("FAIL b2b_done: done=%b, required 1", done);
        else passed++;
        set_h(0, 3, -3, 6);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            e = W'(exp_second[i]);
            total++;
            if (out_valid !== 1'b1 || out_idx !== 4'(i) || out_data !== e)
                $display("FAIL b2b_idx%0d: valid=%b idx=%0d data=%0d, required 1 %0d %0d",
                         i, out_valid, out_idx, $signed(out_data), i, exp_second[i]);
            else passed++;
            @(negedge clk);
        end
        total++;
        if (done !== 1'b1)
            $display("FAIL b2b_done2: done=%b, required 1", done);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation(1'b0);
        test_saturation(1'b1);
        test_snapshot();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
